// File: rtl/csi_rx_pkg.sv
// Shared definitions for the CSI-2 RAW8 pixel unpacker.
// Covers the payload-word FIFO entry layout, the counter width defaults and the pair-half state.
package csi_rx_pkg;

  localparam int X_BITS_DEF = 12;
  localparam int Y_BITS_DEF = 12;

  // FIFO entry = {payload_data, sol_tag, sof_tag}
  localparam int ENTRY_W  = 34;
  localparam int SOF_BIT  = 0;
  localparam int SOL_BIT  = 1;
  localparam int DATA_LSB = 2;
  localparam int DATA_MSB = 33;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_e;

endpackage

// File: rtl/csi_rx_pixel_unpack_if.sv
// Push/pop bundle between the unpacker control logic and its payload-word FIFO.
import csi_rx_pkg::*;

interface csi_rx_pixel_unpack_if;
  logic               push;
  logic [ENTRY_W-1:0] push_entry;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;

  modport master (output push, push_entry, pop, input head, full, empty);
  modport slave  (input push, push_entry, pop, output head, full, empty);
endinterface

// File: rtl/csi_word_fifo.sv
// Synchronous show-ahead FIFO of tagged payload words.
// The head entry is valid in the cycle after the push; a push at full succeeds only alongside a pop.
module csi_word_fifo
  import csi_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  csi_rx_pixel_unpack_if.slave  fifo
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = fifo.pop & (count_q != '0);
    do_push  = fifo.push & ((count_q != CNT_FULL) | do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= fifo.push_entry;
  end

  assign fifo.head  = mem_q[rd_ptr_q];
  assign fifo.full  = (count_q == CNT_FULL);
  assign fifo.empty = (count_q == '0);

endmodule

// File: rtl/csi_rx_pixel_unpack.sv
// Unpacks 32-bit CSI-2 RAW8 payload words into 16-bit pixel pairs.
// Each pair carries column/line coordinates and start-of-line/frame markers on a valid/ready stream.
module csi_rx_pixel_unpack
  import csi_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int X_BITS     = X_BITS_DEF,
  parameter int Y_BITS     = Y_BITS_DEF
) (
  input  logic              clock,
  input  logic              areset_n,
  input  logic [31:0]       payload_data,
  input  logic              payload_enable,
  input  logic              payload_frame,
  input  logic              vsync,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [X_BITS-1:0] pix_x,
  output logic [Y_BITS-1:0] pix_y,
  output logic              pix_sol,
  output logic              pix_sof,
  output logic              overflow
);

  csi_rx_pixel_unpack_if fifo_if ();

  csi_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock),
    .rst_n (areset_n),
    .fifo  (fifo_if)
  );

  logic              frame_q, frame_d;
  logic              sol_pend_q, sol_pend_d;
  logic              sof_pend_q, sof_pend_d;
  logic              overflow_q, overflow_d;
  half_e             half_q, half_d;
  logic [X_BITS-1:0] x_next_q, x_next_d;
  logic [Y_BITS-1:0] y_q, y_d;

  logic              frame_rise, sol_tag, sof_tag;
  logic              xfer, pop, drop;
  logic [31:0]       head_data;
  logic              head_sol, head_sof;

  always_comb begin
    head_data  = fifo_if.head[DATA_MSB:DATA_LSB];
    head_sol   = fifo_if.head[SOL_BIT];
    head_sof   = fifo_if.head[SOF_BIT];

    // Input side: tag the first enabled word of each packet, and the first line after vsync.
    frame_rise = payload_frame & ~frame_q;
    sol_tag    = payload_enable & (sol_pend_q | frame_rise);
    sof_tag    = sol_tag & sof_pend_q;

    pix_valid  = ~fifo_if.empty;
    xfer       = pix_valid & pix_ready;
    pop        = xfer & (half_q == HALF_HI);
    drop       = payload_enable & fifo_if.full & ~pop;

    pix_data   = '0;
    pix_sol    = 1'b0;
    pix_sof    = 1'b0;
    if (pix_valid) begin
      pix_data = (half_q == HALF_LO) ? head_data[15:0] : head_data[31:16];
      pix_sol  = (half_q == HALF_LO) & head_sol;
      pix_sof  = (half_q == HALF_LO) & head_sof;
    end

    // Coordinates come from registers that only move on a transfer, so they hold during stalls.
    pix_x = pix_sol ? '0 : x_next_q;
    if (pix_sof)      pix_y = '0;
    else if (pix_sol) pix_y = y_q + Y_BITS'(1);
    else              pix_y = y_q;

    half_d   = half_q;
    x_next_d = x_next_q;
    y_d      = y_q;
    if (xfer) begin
      half_d   = (half_q == HALF_LO) ? HALF_HI : HALF_LO;
      x_next_d = pix_x + X_BITS'(2);
      y_d      = pix_y;
    end

    frame_d    = payload_frame;
    sol_pend_d = (sol_pend_q | frame_rise) & ~payload_enable;
    sof_pend_d = vsync | (sof_pend_q & ~sol_tag);
    overflow_d = drop | (overflow_q & ~vsync);
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      frame_q    <= 1'b0;
      sol_pend_q <= 1'b0;
      sof_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      half_q     <= HALF_LO;
      x_next_q   <= '0;
      y_q        <= '0;
    end else begin
      frame_q    <= frame_d;
      sol_pend_q <= sol_pend_d;
      sof_pend_q <= sof_pend_d;
      overflow_q <= overflow_d;
      half_q     <= half_d;
      x_next_q   <= x_next_d;
      y_q        <= y_d;
    end
  end

  // A push at full is still accepted when the head word leaves in the same cycle.
  assign fifo_if.push       = payload_enable & (~fifo_if.full | pop);
  assign fifo_if.push_entry = {payload_data, sol_tag, sof_tag};
  assign fifo_if.pop        = pop;
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_csi_rx_pixel_unpack.sv
// Directed bench for csi_rx_pixel_unpack: table-driven lines plus overflow, stall and reset sequences.
module tb_csi_rx_pixel_unpack;

  typedef struct packed {
    logic [15:0] d;
    logic [11:0] x;
    logic [11:0] y;
    logic        sol;
    logic        sof;
  } pair_t;

  typedef struct packed {
    logic            vs;
    logic [31:0]     w0;
    logic [31:0]     w1;
    logic [3:0][15:0] p;
    logic [11:0]     y;
    logic            sof;
  } line_vec_t;

  logic        clock = 1'b0;
  logic        areset_n;
  logic [31:0] payload_data;
  logic        payload_enable, payload_frame, vsync;
  logic [15:0] pix_data;
  logic        pix_valid, pix_ready;
  logic [11:0] pix_x, pix_y;
  logic        pix_sol, pix_sof, overflow;

  always #5 clock = ~clock;

  csi_rx_pixel_unpack #(.FIFO_DEPTH(4), .X_BITS(12), .Y_BITS(12)) dut (
    .clock          (clock),
    .areset_n       (areset_n),
    .payload_data   (payload_data),
    .payload_enable (payload_enable),
    .payload_frame  (payload_frame),
    .vsync          (vsync),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_sol        (pix_sol),
    .pix_sof        (pix_sof),
    .overflow       (overflow)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  pair_t     got_q[$];
  logic      stab_en    = 1'b0;
  logic      prev_stall = 1'b0;
  pair_t     held;
  line_vec_t lines [3];
  logic [31:0] ov_w [5];
  logic [15:0] exp39 [10];
  pair_t     p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pairs(input int n, input int budget, input string name);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(name, 64'(got_q.size() >= n), 64'(1));
  endtask

  function automatic pair_t cur_out();
    pair_t r;
    r.d   = pix_data;
    r.x   = pix_x;
    r.y   = pix_y;
    r.sol = pix_sol;
    r.sof = pix_sof;
    return r;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},    64'(pix_valid), 64'(0));
    check({tag, "_data"},     64'(pix_data),  64'(0));
    check({tag, "_x"},        64'(pix_x),     64'(0));
    check({tag, "_y"},        64'(pix_y),     64'(0));
    check({tag, "_sol"},      64'(pix_sol),   64'(0));
    check({tag, "_sof"},      64'(pix_sof),   64'(0));
    check({tag, "_overflow"}, 64'(overflow),  64'(0));
  endtask

  // Capture accepted pairs, and while enabled require outputs to hold across a stall.
  always @(negedge clock) begin
    if (stab_en && prev_stall) check("stall_hold", 64'(cur_out()), 64'(held));
    prev_stall = areset_n && pix_valid && !pix_ready;
    held       = cur_out();
    if (areset_n && pix_valid && pix_ready) got_q.push_back(cur_out());
  end

  initial begin
    areset_n       = 1'b0;
    payload_data   = '0;
    payload_enable = 1'b0;
    payload_frame  = 1'b0;
    vsync          = 1'b0;
    pix_ready      = 1'b1;

    lines[0] = '{1'b1, 32'h03020100, 32'h07060504,
                 {16'h0706, 16'h0504, 16'h0302, 16'h0100}, 12'd0, 1'b1};
    lines[1] = '{1'b0, 32'h0B0A0908, 32'h0F0E0D0C,
                 {16'h0F0E, 16'h0D0C, 16'h0B0A, 16'h0908}, 12'd1, 1'b0};
    lines[2] = '{1'b1, 32'hDDCCBBAA, 32'h44332211,
                 {16'h4433, 16'h2211, 16'hDDCC, 16'hBBAA}, 12'd0, 1'b1};
    ov_w  = '{32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140, 32'h53525150};
    exp39 = '{16'h1110, 16'h1312, 16'h2120, 16'h2322, 16'h3130,
              16'h3332, 16'h4140, 16'h4342, 16'h6160, 16'h6362};

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero_outputs("reset");
    tick();
    areset_n = 1'b1;
    tick();

    // Table-driven two-word lines with pix_ready held high.
    for (int i = 0; i < 3; i++) begin
      got_q.delete();
      if (lines[i].vs) begin
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
      end
      payload_frame  = 1'b1;
      payload_enable = 1'b1;
      payload_data   = lines[i].w0;
      tick();
      payload_data   = lines[i].w1;
      tick();
      payload_enable = 1'b0;
      payload_frame  = 1'b0;
      tick();
      wait_pairs(4, 20, "line_pairs");
      for (int k = 0; k < 4; k++) begin
        if (got_q.size() != 0) begin
          p = got_q.pop_front();
          check("line_data", 64'(p.d),   64'(lines[i].p[k]));
          check("line_x",    64'(p.x),   64'(2 * k));
          check("line_y",    64'(p.y),   64'(lines[i].y));
          check("line_sol",  64'(p.sol), 64'(k == 0));
          check("line_sof",  64'(p.sof), 64'((k == 0) && lines[i].sof));
        end
      end
    end

    // Overflow: five words into a depth-4 FIFO with the output stalled.
    got_q.delete();
    pix_ready      = 1'b0;
    payload_frame  = 1'b1;
    payload_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      payload_data = ov_w[i];
      tick();
    end
    payload_enable = 1'b0;
    @(negedge clock);
    check("ovf_set",   64'(overflow), 64'(1));
    check("full_hold", 64'(pix_data), 64'(16'h1110));
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    @(negedge clock);
    check("ovf_clear_vsync", 64'(overflow), 64'(0));
    tick();
    vsync          = 1'b1;
    payload_enable = 1'b1;
    payload_data   = 32'h99999999;
    tick();
    vsync          = 1'b0;
    payload_enable = 1'b0;
    @(negedge clock);
    check("ovf_set_wins", 64'(overflow), 64'(1));
    check("drop_hold",    64'(pix_data), 64'(16'h1110));
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    @(negedge clock);
    check("ovf_clear_again", 64'(overflow), 64'(0));

    // Push at full in the same cycle as the half-1 pop.
    tick();
    pix_ready      = 1'b1;
    tick();
    payload_enable = 1'b1;
    payload_data   = 32'h63626160;
    tick();
    payload_enable = 1'b0;
    pix_ready      = 1'b0;
    @(negedge clock);
    check("full_pushpop_ovf",  64'(overflow), 64'(0));
    check("full_pushpop_head", 64'(pix_data), 64'(16'h2120));
    tick();
    pix_ready = 1'b1;
    wait_pairs(10, 40, "full_drain_pairs");
    for (int k = 0; k < 10; k++) begin
      if (got_q.size() != 0) begin
        p = got_q.pop_front();
        check("full_drain_data", 64'(p.d), 64'(exp39[k]));
        check("full_drain_x",    64'(p.x), 64'(2 * k));
        if (k == 0) check("full_drain_y", 64'(p.y), 64'(1));
      end
    end
    tick();
    payload_frame = 1'b0;
    tick();

    // 640-byte line, one word every five cycles, random single-cycle stalls.
    got_q.delete();
    stab_en = 1'b1;
    fork
      begin
        payload_frame = 1'b1;
        for (int w = 0; w < 160; w++) begin
          payload_enable = 1'b1;
          payload_data   = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
          tick();
          payload_enable = 1'b0;
          repeat (4) tick();
        end
        payload_frame = 1'b0;
      end
      begin
        int   cyc  = 0;
        logic last = 1'b1;
        while (got_q.size() < 320 && cyc < 4000) begin
          pix_ready = last ? 1'($urandom_range(0, 1)) : 1'b1;
          last      = pix_ready;
          tick();
          cyc++;
        end
      end
    join
    stab_en   = 1'b0;
    pix_ready = 1'b1;
    check("long_count",    64'(got_q.size()), 64'(320));
    check("long_overflow", 64'(overflow),     64'(0));
    for (int k = 0; k < 320; k++) begin
      if (got_q.size() != 0) begin
        p = got_q.pop_front();
        check("long_data", 64'(p.d), 64'({8'(2*k+1), 8'(2*k)}));
        check("long_x",    64'(p.x), 64'(2 * k));
        if (k == 0) begin
          check("long_first_sol", 64'(p.sol), 64'(1));
          check("long_first_sof", 64'(p.sof), 64'(1));
          check("long_first_y",   64'(p.y),   64'(0));
        end
        if (k == 319) check("long_last_x", 64'(p.x), 64'(638));
      end
    end

    // Reset mid-line with three words buffered.
    got_q.delete();
    pix_ready     = 1'b0;
    payload_frame = 1'b0;
    tick();
    payload_frame  = 1'b1;
    payload_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      payload_data = ov_w[i];
      tick();
    end
    payload_enable = 1'b0;
    @(negedge clock);
    check("pre_reset_valid", 64'(pix_valid), 64'(1));
    tick();
    areset_n = 1'b0;
    @(negedge clock);
    check_zero_outputs("midline_reset");
    tick();
    areset_n      = 1'b1;
    payload_frame = 1'b0;
    tick();
    @(negedge clock);
    check("post_reset_empty", 64'(pix_valid), 64'(0));
    tick();
    payload_frame  = 1'b1;
    payload_enable = 1'b1;
    payload_data   = 32'hC3C2C1C0;
    tick();
    payload_enable = 1'b0;
    pix_ready      = 1'b1;
    wait_pairs(2, 20, "post_reset_pairs");
    if (got_q.size() != 0) begin
      p = got_q.pop_front();
      check("post_reset_data0", 64'(p.d),   64'(16'hC1C0));
      check("post_reset_sol",   64'(p.sol), 64'(1));
      check("post_reset_sof",   64'(p.sof), 64'(0));
      check("post_reset_x0",    64'(p.x),   64'(0));
      check("post_reset_y",     64'(p.y),   64'(1));
    end
    if (got_q.size() != 0) begin
      p = got_q.pop_front();
      check("post_reset_data1", 64'(p.d), 64'(16'hC3C2));
      check("post_reset_x1",    64'(p.x), 64'(2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csi_rx_pixel_unpack.md
CSI_RX_PIXEL_UNPACK -- requirements
Module: csi_rx_pixel_unpack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning payload-word buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter X_BITS, default 12, meaning pixel column counter width.
REQ-003 SHALL have parameter Y_BITS, default 12, meaning line counter width.
REQ-004 SHALL have port clock, input, 1, the single clock (CSI word clock); one clock only.
REQ-005 SHALL have port areset_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port payload_data, input, 32, RAW8 payload word; byte0=[7:0] is the earliest pixel.
REQ-007 SHALL have port payload_enable, input, 1, payload_data valid this cycle.
REQ-008 SHALL have port payload_frame, input, 1, high for the duration of one long packet (line).
REQ-009 SHALL have port vsync, input, 1, one-cycle frame-start pulse.
REQ-010 SHALL have port pix_data, output, 16, pixel pair; [7:0]=even pixel, [15:8]=odd pixel.
REQ-011 SHALL have port pix_valid, output, 1, pix_data and sideband valid.
REQ-012 SHALL have port pix_ready, input, 1, downstream accepts; transfer = pix_valid & pix_ready.
REQ-013 SHALL have port pix_x, output, X_BITS, column of the even pixel in pix_data.
REQ-014 SHALL have port pix_y, output, Y_BITS, line index within frame.
REQ-015 SHALL have port pix_sol, output, 1, pair is first of a line.
REQ-016 SHALL have port pix_sof, output, 1, pair is first of a frame.
REQ-017 SHALL have port overflow, output, 1, sticky: a payload word was dropped.

Function
REQ-018 SHALL push {payload_data, sol_tag, sof_tag} into the FIFO on every cycle with payload_enable=1 and FIFO not full.
REQ-019 SHALL set sol_tag on the first enabled word after payload_frame rises (0->1); later words in that packet get sol_tag=0.
REQ-020 SHALL latch a pending-SOF flag on vsync and set sof_tag on the next sol_tag word, clearing the flag in that cycle.
REQ-021 SHALL keep the FIFO show-ahead: a word pushed at edge N is presented at pix_data in the cycle after edge N (latency 1 cycle).
REQ-022 SHALL present each word as two pairs: half 0 = bytes 1:0, then half 1 = bytes 3:2; pop the word on transfer of half 1.
REQ-023 SHALL hold pix_data and all sideband stable while pix_valid=1 and pix_ready=0.
REQ-024 SHALL assert pix_sol/pix_sof only on half 0 of a tagged word.
REQ-025 SHALL set pix_x=0 on a pix_sol pair, else previous accepted pix_x+2, wrapping modulo 2^X_BITS.
REQ-026 SHALL set pix_y=0 on a pix_sof pair, previous pix_y+1 on a pix_sol-only pair, else unchanged; wrap modulo 2^Y_BITS.
REQ-027 SHALL accept a push when FIFO full only if a pop occurs in the same cycle (simultaneous push/pop at full: both succeed, occupancy unchanged).
REQ-028 SHALL, on payload_enable with FIFO full and no pop, drop the word and set overflow.
REQ-029 SHALL clear overflow on vsync; if vsync and a drop coincide, overflow ends 1 (set wins).
REQ-030 SHALL, when FIFO empty, drive pix_valid=0; push into empty FIFO with pix_ready=1 yields back-to-back pairs with no bubble.
REQ-031 SHALL sustain 2 pixels/cycle at the output, i.e. one word per 2 cycles with pix_ready held high, without overflow.

Reset
REQ-032 SHALL, while areset_n=0, force: FIFO empty, half pointer 0, pending-SOF 0, packet-edge tracker 0, overflow 0, pix_valid 0, pix_sol 0, pix_sof 0, pix_x 0, pix_y 0, pix_data 0.
REQ-033 SHALL discard FIFO contents on reset mid-line; first word after release is tagged only per REQ-019/020 relative to post-reset edges.

Structure
REQ-034 SHALL place FIFO entry field positions (data, sol, sof bits) and X_BITS/Y_BITS defaults in shared package csi_rx_pkg.
REQ-035 SHALL implement storage as sub-module csi_word_fifo (synchronous show-ahead FIFO, width 34, full/empty flags).

Verification
REQ-036 vsync, then line of 2 words 0x03020100,0x07060504, pix_ready=1 -> pairs 0x0100,0x0302,0x0504,0x0706; pix_x 0,2,4,6; first pair pix_sof=pix_sol=1, pix_y=0.
REQ-037 Second line after REQ-036 -> first pair pix_sol=1, pix_sof=0, pix_y=1, pix_x=0.
REQ-038 pix_ready=0, FIFO_DEPTH=4, 5 words pushed -> 5th dropped, overflow=1; next vsync -> overflow=0.
REQ-039 FIFO full, pix_ready=1 on half 1, new payload_enable same cycle -> word accepted, overflow stays 0.
REQ-040 Random pix_ready stalls, 640-byte line -> 320 pairs, data in order, last pix_x=638, outputs stable during stalls.
REQ-041 areset_n low mid-line with 3 words buffered -> pix_valid=0 next cycle, all outputs per REQ-032.
